// File: rtl/speed_occupancy_dp_pkg.sv
// Shared state type and elaboration helpers for the speed/occupancy datapath.
package speed_dp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    DIVIDE = 2'd2
  } dp_state_e;

  function automatic int unsigned ticks_per_ms(input int unsigned clk_hz);
    return clk_hz / 32'd1000;
  endfunction

  // Low 'width' bits set; callers truncate to their own vector width.
  function automatic logic [31:0] all_ones(input int unsigned width);
    logic [31:0] mask_v;
    if (width >= 32'd32) begin
      mask_v = 32'hFFFF_FFFF;
    end else begin
      mask_v = (32'd1 << width) - 32'd1;
    end
    return mask_v;
  endfunction

endpackage

// File: rtl/speed_occupancy_dp_if.sv
// Sensor, vehicle and barrier handshakes plus status outputs of the gate datapath.
interface speed_occupancy_dp_if #(
  parameter int WIDTH_VEH   = 3,
  parameter int WIDTH_SPEED = 14
);
  logic                   start;
  logic                   stop;
  logic                   veh_in;
  logic                   veh_out;
  logic                   open_req;
  logic                   close_req;
  logic [WIDTH_VEH-1:0]   num_veh;
  logic                   full;
  logic                   empty;
  logic [WIDTH_SPEED-1:0] speed;
  logic                   speed_valid;
  logic                   busy;
  logic                   timeout;
  logic                   overspeed;
  logic                   en_barrier;

  modport master (
    output start, stop, veh_in, veh_out, open_req, close_req,
    input  num_veh, full, empty, speed, speed_valid, busy, timeout, overspeed, en_barrier
  );

  modport slave (
    input  start, stop, veh_in, veh_out, open_req, close_req,
    output num_veh, full, empty, speed, speed_valid, busy, timeout, overspeed, en_barrier
  );
endinterface

// File: rtl/speed_occupancy_dp_seq_div.sv
// Restoring divider, one quotient bit per cycle; done and quotient are valid
// in the last iteration cycle so the caller can register them directly.
module seq_div
  import speed_dp_pkg::*;
#(
  parameter int N = 14,
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic         done,
  output logic         busy
);
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0]  SAT_C   = N'(all_ones(N));
  localparam logic [CW-1:0] CNT_N_C = CW'(N);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [N-1:0]  quo_r;
  logic [D-1:0]  rem_r;
  logic [D-1:0]  dvs_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic [D:0]    rem_shift_s;
  logic          ge_s;
  logic [N-1:0]  quo_next_s;
  logic [D-1:0]  rem_next_s;

  // One restoring step: the partial remainder stays below the divisor, so D bits hold it.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[N-1]};
    ge_s        = (rem_shift_s >= {1'b0, dvs_r});
    quo_next_s  = {quo_r[N-2:0], ge_s};
    if (ge_s) begin
      rem_next_s = D'(rem_shift_s - {1'b0, dvs_r});
    end else begin
      rem_next_s = rem_shift_s[D-1:0];
    end
  end

  assign done     = busy_r && (cnt_r == ONE_C);
  assign quotient = (dvs_r == {D{1'b0}}) ? SAT_C : quo_next_s;
  assign busy     = busy_r;

  // Iteration registers: load on start, then shift one bit per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo_r  <= {N{1'b0}};
      rem_r  <= {D{1'b0}};
      dvs_r  <= {D{1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
    end else if (start) begin
      quo_r  <= dividend;
      rem_r  <= {D{1'b0}};
      dvs_r  <= divisor;
      cnt_r  <= CNT_N_C;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      quo_r  <= quo_next_s;
      rem_r  <= rem_next_s;
      cnt_r  <= cnt_r - ONE_C;
      busy_r <= (cnt_r != ONE_C);
    end
  end

endmodule

// File: rtl/speed_occupancy_dp.sv
// Gate datapath: sensor-to-sensor timing, speed divide, occupancy and barrier drive.
// Build option OVERSPEED_EN adds the registered speed-limit comparator.
module speed_occupancy_dp
  import speed_dp_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int WIDTH_MS    = 12,
  parameter int WIDTH_SPEED = 14,
  parameter int DIST_CONST  = 14400,
  parameter int MAX_VEH     = 7,
  parameter int WIDTH_VEH   = 3,
  parameter int SPEED_LIMIT = 60
) (
  input logic                 clk,
  input logic                 reset_n,
  speed_occupancy_dp_if.slave bus
);
  localparam int unsigned TICKS = ticks_per_ms(int'(CLK_HZ));
  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TICK_W-1:0]      TICK_LAST_C = TICK_W'(TICKS - 1);
  localparam logic [TICK_W-1:0]      TICK_ONE_C  = TICK_W'(1);
  localparam logic [WIDTH_MS-1:0]    MS_ONE_C    = WIDTH_MS'(1);
  localparam logic [WIDTH_MS-1:0]    MS_LAST_C   = WIDTH_MS'(all_ones(WIDTH_MS) - 32'd1);
  localparam logic [WIDTH_SPEED-1:0] DIST_C      = WIDTH_SPEED'(DIST_CONST);
  localparam logic [WIDTH_VEH-1:0]   MAX_C       = WIDTH_VEH'(MAX_VEH);
  localparam logic [WIDTH_VEH-1:0]   VEH_ONE_C   = WIDTH_VEH'(1);

  dp_state_e              state_r, state_next_s;
  logic [TICK_W-1:0]      tick_r;
  logic [WIDTH_MS-1:0]    time_ms_r;
  logic                   tick_wrap_s, clr_s, div_start_s, timeout_s, load_s;
  logic [WIDTH_SPEED-1:0] div_quot_s;
  logic                   div_done_s, div_busy_s;
  logic [WIDTH_SPEED-1:0] speed_r;
  logic                   speed_valid_r, timeout_r, busy_r;
  logic [WIDTH_VEH-1:0]   num_veh_r, num_next_s;
  logic                   full_r, empty_r, en_barrier_r;

  assign tick_wrap_s = (tick_r == TICK_LAST_C);

  seq_div #(.N(WIDTH_SPEED), .D(WIDTH_MS)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start_s),
    .dividend (DIST_C),
    .divisor  (time_ms_r),
    .quotient (div_quot_s),
    .done     (div_done_s),
    .busy     (div_busy_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Next state and control strobes; start outranks stop, stop outranks timeout.
  always_comb begin
    state_next_s = state_r;
    clr_s        = 1'b0;
    div_start_s  = 1'b0;
    timeout_s    = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          clr_s        = 1'b1;
          state_next_s = TIMING;
        end else begin
          state_next_s = IDLE;
        end
      end
      TIMING: begin
        if (bus.start) begin
          clr_s = 1'b1;
        end else if (bus.stop) begin
          div_start_s  = 1'b1;
          state_next_s = DIVIDE;
        end else if (tick_wrap_s && (time_ms_r == MS_LAST_C)) begin
          timeout_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = TIMING;
        end
      end
      DIVIDE: begin
        if (div_done_s) begin
          load_s       = 1'b1;
          state_next_s = IDLE;
        end else if (!div_busy_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DIVIDE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Tick and millisecond counters advance only while timing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_r    <= {TICK_W{1'b0}};
      time_ms_r <= {WIDTH_MS{1'b0}};
    end else if (clr_s) begin
      tick_r    <= {TICK_W{1'b0}};
      time_ms_r <= {WIDTH_MS{1'b0}};
    end else if (state_r == TIMING) begin
      if (tick_wrap_s) begin
        tick_r    <= {TICK_W{1'b0}};
        time_ms_r <= time_ms_r + MS_ONE_C;
      end else begin
        tick_r <= tick_r + TICK_ONE_C;
      end
    end
  end

  // Speed result and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_r       <= {WIDTH_SPEED{1'b0}};
      speed_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      if (load_s) speed_r <= div_quot_s;
      speed_valid_r <= load_s;
      timeout_r     <= timeout_s;
      busy_r        <= (state_next_s != IDLE);
    end
  end

`ifdef OVERSPEED_EN
  localparam logic [WIDTH_SPEED-1:0] LIMIT_C = WIDTH_SPEED'(SPEED_LIMIT);
  logic overspeed_r;

  // Overspeed flag refreshes together with the speed it describes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    overspeed_r <= 1'b0;
    else if (load_s) overspeed_r <= (div_quot_s > LIMIT_C);
  end

  assign bus.overspeed = overspeed_r;
`else
  assign bus.overspeed = 1'b0;
`endif

  // Saturating occupancy: simultaneous in/out cancels, never wraps.
  always_comb begin
    num_next_s = num_veh_r;
    if (bus.veh_in && !bus.veh_out && (num_veh_r != MAX_C)) begin
      num_next_s = num_veh_r + VEH_ONE_C;
    end else if (bus.veh_out && !bus.veh_in && (num_veh_r != {WIDTH_VEH{1'b0}})) begin
      num_next_s = num_veh_r - VEH_ONE_C;
    end else begin
      num_next_s = num_veh_r;
    end
  end

  // Occupancy and barrier registers; close_req dominates open_req.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_veh_r    <= {WIDTH_VEH{1'b0}};
      full_r       <= 1'b0;
      empty_r      <= 1'b0;
      en_barrier_r <= 1'b0;
    end else begin
      num_veh_r <= num_next_s;
      full_r    <= (num_next_s == MAX_C);
      empty_r   <= (num_next_s == {WIDTH_VEH{1'b0}});
      if (bus.close_req) begin
        en_barrier_r <= 1'b0;
      end else if (bus.open_req && (num_veh_r != MAX_C)) begin
        en_barrier_r <= 1'b1;
      end
    end
  end

  assign bus.num_veh     = num_veh_r;
  assign bus.full        = full_r;
  assign bus.empty       = empty_r;
  assign bus.speed       = speed_r;
  assign bus.speed_valid = speed_valid_r;
  assign bus.busy        = busy_r;
  assign bus.timeout     = timeout_r;
  assign bus.en_barrier  = en_barrier_r;

endmodule

// File: tb/tb_speed_occupancy_dp.sv
// Self-checking bench for speed_occupancy_dp: random timings and occupancy traffic
// against an arithmetic model of speed, timeout, occupancy and barrier rules.
module tb_speed_occupancy_dp;
  localparam int unsigned TICKS = 50;
  localparam int unsigned WS    = 14;
  localparam int unsigned ALL1  = 16383;
  localparam int unsigned DIST  = 14400;
  localparam int unsigned MAXV  = 7;
  localparam int unsigned LIMIT = 60;
  localparam int unsigned MS_MAX = 255;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int unsigned m_speed = 0;
  int unsigned m_ovs = 0;
  int unsigned m_occ = 0;
  int unsigned m_en = 0;

  speed_occupancy_dp_if #(.WIDTH_VEH(3), .WIDTH_SPEED(14)) bus ();

  speed_occupancy_dp #(
    .CLK_HZ(50_000), .WIDTH_MS(8), .WIDTH_SPEED(14), .DIST_CONST(14400),
    .MAX_VEH(7), .WIDTH_VEH(3), .SPEED_LIMIT(60)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_num_veh"}, 32'(bus.num_veh), 32'd0);
    check_eq({tag, "_full"}, 32'(bus.full), 32'd0);
    check_eq({tag, "_empty"}, 32'(bus.empty), 32'd0);
    check_eq({tag, "_speed"}, 32'(bus.speed), 32'd0);
    check_eq({tag, "_speed_valid"}, 32'(bus.speed_valid), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
    check_eq({tag, "_overspeed"}, 32'(bus.overspeed), 32'd0);
    check_eq({tag, "_en_barrier"}, 32'(bus.en_barrier), 32'd0);
  endtask

  function automatic int unsigned ovs_model(input int unsigned spd);
`ifdef OVERSPEED_EN
    return (spd > LIMIT) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // pre != 0: a first start, then after pre cycles a start+stop pair (start must win).
  task automatic do_speed(input int unsigned pre, input int unsigned d, input string tag);
    int unsigned ms;
    int lat;
    ms      = (d - 1) / TICKS;
    m_speed = (ms == 0) ? ALL1 : DIST / ms;
    m_ovs   = ovs_model(m_speed);
    if (pre != 0) begin
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (pre - 1) @(negedge clk);
    end else begin
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.stop  = (pre != 0);
    @(negedge clk); bus.start = 1'b0; bus.stop = 1'b0;
    check_eq({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
    repeat (d - 1) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    lat = 1;
    while (bus.speed_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(WS + 1));
    check_eq({tag, "_speed"}, 32'(bus.speed), 32'(m_speed));
    check_eq({tag, "_overspeed"}, 32'(bus.overspeed), 32'(m_ovs));
    check_eq({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid_pulse"}, 32'(bus.speed_valid), 32'd0);
    check_eq({tag, "_speed_hold"}, 32'(bus.speed), 32'(m_speed));
  endtask

  task automatic occ_step(input bit vi, input bit vo, input bit op, input bit cl);
    @(negedge clk);
    bus.veh_in = vi; bus.veh_out = vo; bus.open_req = op; bus.close_req = cl;
    if (cl) m_en = 0;
    else if (op && m_occ != MAXV) m_en = 1;
    if (vi && !vo && m_occ < MAXV) m_occ++;
    else if (vo && !vi && m_occ > 0) m_occ--;
    @(posedge clk); #1;
    check_eq("num_veh", 32'(bus.num_veh), 32'(m_occ));
    check_eq("full", 32'(bus.full), 32'(m_occ == MAXV));
    check_eq("empty", 32'(bus.empty), 32'(m_occ == 0));
    check_eq("en_barrier", 32'(bus.en_barrier), 32'(m_en));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    bus.start = 1'b0; bus.stop = 1'b0; bus.veh_in = 1'b0; bus.veh_out = 1'b0;
    bus.open_req = 1'b0; bus.close_req = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // stop while idle is ignored
    @(negedge clk); bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(bus.busy) + int'(bus.speed_valid);
    end
    check_eq("idle_stop_ignored", 32'(seen), 32'd0);

    do_speed(0, 6001, "speed120");
    check_eq("speed120_const", 32'(bus.speed), 32'd120);
    do_speed(0, 10, "divzero");
    check_eq("divzero_const", 32'(bus.speed), 32'd16383);
    do_speed(0, 11801, "limit61");
    do_speed(0, 12001, "limit60");
    do_speed(2000, 1501, "restart");
    for (int i = 0; i < 6; i++) begin
      do_speed(0, $urandom_range(1, 2000), "rand_speed");
    end

    // timeout: no stop, ms counter saturates
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    lat = 1;
    while (bus.timeout !== 1'b1 && lat < 13000) begin
      @(negedge clk);
      lat++;
    end
    check_eq("timeout_latency", 32'(lat), 32'(MS_MAX * TICKS + 1));
    check_eq("timeout_busy", 32'(bus.busy), 32'd0);
    check_eq("timeout_speed", 32'(bus.speed), 32'(m_speed));
    check_eq("timeout_no_valid", 32'(bus.speed_valid), 32'd0);
    check_eq("timeout_overspeed", 32'(bus.overspeed), 32'(m_ovs));
    @(negedge clk);
    check_eq("timeout_pulse", 32'(bus.timeout), 32'd0);

    // occupancy and barrier, directed
    repeat (8) occ_step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("occ_fill_const", 32'(bus.num_veh), 32'd7);
    check_eq("occ_full_const", 32'(bus.full), 32'd1);
    occ_step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("occ_both_const", 32'(bus.num_veh), 32'd7);
    occ_step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("open_at_full_const", 32'(bus.en_barrier), 32'd0);
    repeat (8) occ_step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("occ_drain_const", 32'(bus.num_veh), 32'd0);
    check_eq("occ_empty_const", 32'(bus.empty), 32'd1);
    repeat (3) occ_step(1'b1, 1'b0, 1'b0, 1'b0);
    occ_step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("open_close_const", 32'(bus.en_barrier), 32'd0);
    occ_step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("open_const", 32'(bus.en_barrier), 32'd1);

    // occupancy and barrier, random traffic biased up then down
    for (int i = 0; i < 160; i++) begin
      int unsigned up_pct;
      up_pct = (i < 80) ? 60 : 20;
      occ_step($urandom_range(0, 99) < up_pct, $urandom_range(0, 99) < (80 - up_pct),
               $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15);
    end
    repeat (3) occ_step(1'b1, 1'b0, 1'b1, 1'b0);
    occ_step(1'b0, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a divide
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (599) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_div_reset");
    m_occ = 0; m_en = 0; m_speed = 0; m_ovs = 0;
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(bus.busy) + int'(bus.speed_valid);
    end
    check_eq("no_valid_after_reset", 32'(seen), 32'd0);
    occ_step(1'b0, 1'b0, 1'b0, 1'b0);
    do_speed(0, 2501, "post_reset");
    check_eq("post_reset_const", 32'(bus.speed), 32'd288);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
